// File: rtl/rx_frame_assembler.sv
// Frame assembler for MIPI RX 48-bit pixel words: hunts for a sync word, collects
// DLEN payload bytes, validates an XOR trailer and presents good frames until acknowledged.
module rx_frame_assembler #(
  parameter int unsigned DLEN      = 6,
  parameter logic [47:0] SYNC_WORD = 48'h7E7E7E7E7E7E,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                rx_pixel_clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [47:0]         in_data,
  output logic [DLEN*8-1:0]   out_data,
  output logic                out_valid,
  output logic                out_available,
  input  logic                out_ack,
  output logic                crc_err,
  output logic                timeout,
  output logic                overflow,
  output logic [15:0]         frame_count
);

  localparam int unsigned NW  = DLEN / 6;
  localparam int unsigned PW  = NW * 48;
  localparam int unsigned WCW = $clog2(NW + 1);
  localparam int unsigned ICW = $clog2(TIMEOUT + 1);

  if ((DLEN % 6) != 0 || DLEN < 6) begin : g_dlen_check
    $error("rx_frame_assembler: DLEN must be a multiple of 6 and at least 6");
  end

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("rx_frame_assembler: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    TRAILER
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   word_cnt;
  logic [ICW-1:0]   idle_cnt;
  logic [PW-1:0]    shreg;
  logic [PW-1:0]    shreg_shifted;
  logic [47:0]      acc;

  logic             start_frame;
  logic             shift_en;
  logic             trailer_seen;
  logic             idle_abort;
  logic             frame_good;
  logic             frame_bad;
  logic             frame_load;
  logic             frame_drop;

  // A one-word frame has nothing older to keep, so the shift degenerates to a load.
  if (NW == 1) begin : g_single_word
    assign shreg_shifted = in_data;
  end else begin : g_multi_word
    assign shreg_shifted = {shreg[PW-49:0], in_data};
  end

  // The TIMEOUT-th consecutive idle cycle inside a frame aborts it.
  assign idle_abort = (state_q != HUNT) && !in_valid &&
                      (idle_cnt == ICW'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    shift_en     = 1'b0;
    trailer_seen = 1'b0;

    case (state_q)
      HUNT: begin
        if (in_valid && in_data == SYNC_WORD) begin
          start_frame = 1'b1;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          shift_en = 1'b1;
          if (word_cnt == WCW'(NW - 1)) begin
            state_d = TRAILER;
          end
        end else if (idle_abort) begin
          state_d = HUNT;
        end
      end
      TRAILER: begin
        if (in_valid) begin
          trailer_seen = 1'b1;
          state_d      = HUNT;
        end else if (idle_abort) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign frame_good = trailer_seen && (in_data == acc);
  assign frame_bad  = trailer_seen && (in_data != acc);
  assign frame_load = frame_good && (!out_available || out_ack);
  assign frame_drop = frame_good && out_available && !out_ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the payload shift register and accumulator are reset too, keeping every output free of X after reset.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      shreg    <= '0;
      acc      <= '0;
    end else if (start_frame) begin
      word_cnt <= '0;
      shreg    <= '0;
      acc      <= '0;
    end else if (shift_en) begin
      word_cnt <= word_cnt + WCW'(1);
      shreg    <= shreg_shifted;
      acc      <= acc ^ in_data;
    end
  end

  // Idle counter only runs while a frame is open; any accepted word restarts it.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state_d == HUNT || in_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != ICW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + ICW'(1);
    end
  end

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_available <= 1'b0;
      crc_err       <= 1'b0;
      timeout       <= 1'b0;
      overflow      <= 1'b0;
      frame_count   <= '0;
    end else begin
      out_valid <= frame_load;
      crc_err   <= frame_bad;
      timeout   <= idle_abort;

      // A frame completing in the same cycle as an ack replaces the old one.
      if (frame_load) begin
        out_data      <= shreg;
        out_available <= 1'b1;
        frame_count   <= frame_count + 16'd1;
      end else if (out_ack) begin
        out_available <= 1'b0;
      end

      if (frame_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Scoreboard bench for rx_frame_assembler (DLEN=12, TIMEOUT=15): stimulus queues expected
// output events, a negedge monitor pops and compares every pulse the DUT presents.
module tb_rx_frame_assembler;

  localparam int unsigned DLEN    = 12;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [47:0] SYNC    = 48'h7E7E7E7E7E7E;

  typedef enum logic [1:0] {EV_FRAME, EV_CRC, EV_TMO} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [95:0] data;
    logic [15:0] cnt;
  } ev_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [47:0]       in_data;
  logic [DLEN*8-1:0] out_data;
  logic              out_valid;
  logic              out_available;
  logic              out_ack;
  logic              crc_err;
  logic              timeout;
  logic              overflow;
  logic [15:0]       frame_count;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  rx_frame_assembler #(
    .DLEN     (DLEN),
    .SYNC_WORD(SYNC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .rx_pixel_clk (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_available(out_available),
    .out_ack      (out_ack),
    .crc_err      (crc_err),
    .timeout      (timeout),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [95:0] data, input logic [15:0] cnt);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse on out_valid / crc_err / timeout must match the queue head.
  always @(negedge clk) begin
    if (!rst && (out_valid || crc_err || timeout)) begin
      ev_kind_e act_kind;
      ev_t      e;
      act_kind = out_valid ? EV_FRAME : (crc_err ? EV_CRC : EV_TMO);
      n_checks++;
      if ((32'(out_valid) + 32'(crc_err) + 32'(timeout)) > 1) begin
        n_errors++;
        $display("FAIL multi_pulse: got valid=%b crc=%b tmo=%b expected one pulse",
                 out_valid, crc_err, timeout);
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got kind %s expected no event", act_kind.name());
      end else begin
        e = exp_q.pop_front();
        if (e.kind != act_kind) begin
          n_errors++;
          $display("FAIL event_kind: got %s expected %s", act_kind.name(), e.kind.name());
        end else if (e.kind == EV_FRAME && (out_data !== e.data || frame_count !== e.cnt)) begin
          n_errors++;
          $display("FAIL frame_event: got data %h count %0d expected data %h count %0d",
                   out_data, frame_count, e.data, e.cnt);
        end
      end
    end
  end

  task automatic send_word(input logic [47:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] w1, input logic [47:0] w2, input logic [47:0] tr);
    send_word(SYNC);
    send_word(w1);
    send_word(w2);
    send_word(tr);
  endtask

  task automatic ack_pulse();
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: got %0d pending events expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam logic [47:0] A1 = 48'h112233445566, A2 = 48'h0A0B0C0D0E0F, AT = 48'h1B293F495B69;
  localparam logic [47:0] B1 = 48'hAAAAAAAAAAAA, B2 = 48'h555555555555, BT = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] C1 = 48'h000000000001, C2 = 48'h123456789ABC, CT = 48'h123456789ABD;
  localparam logic [47:0] D1 = 48'hFFFF00000000, D2 = 48'h0000FFFF0000, DT = 48'hFFFFFFFF0000;
  localparam logic [47:0] E1 = 48'hDEADBEEF0000, E2 = 48'h0000CAFEF00D, ET = 48'hDEAD7411F00D;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    out_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", 96'(out_valid), '0);
    check("rst_out_available", 96'(out_available), '0);
    check("rst_crc_err", 96'(crc_err), '0);
    check("rst_timeout", 96'(timeout), '0);
    check("rst_overflow", 96'(overflow), '0);
    check("rst_frame_count", 96'(frame_count), '0);

    // Good frame A.
    expect_ev(EV_FRAME, {A1, A2}, 16'd1);
    send_frame(A1, A2, AT);
    idle(1);
    drain("drain_frame_a", 4);
    check("a_available", 96'(out_available), 96'd1);
    check("a_count", 96'(frame_count), 96'd1);

    // Ack in the same cycle as a good trailer while a frame is held.
    expect_ev(EV_FRAME, {D1, D2}, 16'd2);
    send_word(SYNC);
    send_word(D1);
    send_word(D2);
    out_ack = 1'b1;
    send_word(DT);
    out_ack = 1'b0;
    idle(1);
    drain("drain_frame_d", 4);
    check("d_available", 96'(out_available), 96'd1);
    check("d_overflow", 96'(overflow), '0);
    check("d_out_data", out_data, {D1, D2});

    ack_pulse();
    @(negedge clk);
    check("ack_clears_available", 96'(out_available), '0);

    // Bad trailer.
    expect_ev(EV_CRC, '0, '0);
    send_frame(A1, A2, 48'h1B293F495B68);
    idle(1);
    drain("drain_crc", 4);
    check("crc_available", 96'(out_available), '0);
    check("crc_count", 96'(frame_count), 96'd2);

    // Held frame A, then frame B is dropped.
    expect_ev(EV_FRAME, {A1, A2}, 16'd3);
    send_frame(A1, A2, AT);
    idle(1);
    drain("drain_frame_a2", 4);
    send_frame(B1, B2, BT);
    idle(3);
    check("ovf_overflow", 96'(overflow), 96'd1);
    check("ovf_out_data", out_data, {A1, A2});
    check("ovf_count", 96'(frame_count), 96'd3);
    check("ovf_available", 96'(out_available), 96'd1);

    ack_pulse();
    expect_ev(EV_FRAME, {C1, C2}, 16'd4);
    send_frame(C1, C2, CT);
    idle(1);
    drain("drain_frame_c", 4);
    check("c_overflow_sticky", 96'(overflow), 96'd1);
    ack_pulse();

    // Idle timeout after one payload word, then a good frame.
    expect_ev(EV_TMO, '0, '0);
    send_word(SYNC);
    send_word(E1);
    idle(TIMEOUT);
    drain("drain_timeout", 4);
    expect_ev(EV_FRAME, {E1, E2}, 16'd5);
    send_frame(E1, E2, ET);
    idle(1);
    drain("drain_frame_e", 4);
    ack_pulse();

    // A gap one short of the timeout is tolerated.
    expect_ev(EV_FRAME, {A1, A2}, 16'd6);
    send_word(SYNC);
    send_word(A1);
    idle(TIMEOUT - 1);
    send_word(A2);
    send_word(AT);
    idle(1);
    drain("drain_gap_frame", 4);

    // Back-to-back frames with the consumer acknowledging continuously.
    expect_ev(EV_FRAME, {E1, E2}, 16'd7);
    expect_ev(EV_FRAME, {C1, C2}, 16'd8);
    out_ack = 1'b1;
    send_frame(E1, E2, ET);
    send_frame(C1, C2, CT);
    out_ack = 1'b0;
    idle(1);
    drain("drain_back_to_back", 8);
    check("b2b_count", 96'(frame_count), 96'd8);
    check("b2b_available", 96'(out_available), 96'd1);

    // Reset mid-frame, then garbage without a sync word.
    send_word(SYNC);
    send_word(A1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_out_data", out_data, '0);
    check("midrst_available", 96'(out_available), '0);
    check("midrst_overflow", 96'(overflow), '0);
    check("midrst_count", 96'(frame_count), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(A2);
    send_word(AT);
    send_word(48'h7E7E7E7E7E7F);
    send_word(C1);
    idle(4);
    @(negedge clk);
    check("post_rst_count", 96'(frame_count), '0);
    check("post_rst_available", 96'(out_available), '0);
    check("post_rst_queue_empty", 96'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
